// File: rtl/thread_fetch_unit_if.sv
// Fetch-stage bus: PC table lookup, instruction memory read, branch redirect, IF/ID entry and status.
// Latency: n/a (wiring only).
// Backpressure: none; the fetch stage has no stall path.
interface thread_fetch_unit_if #(
    parameter int INSTR_W = 16
);
    logic               fetch_thread_id;
    logic [7:0]         fetch_pc;
    logic [6:0]         imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               branch_taken;
    logic               branch_thread_id;
    logic               ifid_valid;
    logic               ifid_thread_id;
    logic [7:0]         ifid_pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic [1:0]         thread_active;
    logic               all_halted;
    logic [15:0]        fetch_count0;
    logic [15:0]        fetch_count1;

    // Fetch unit side
    modport master (
        output fetch_thread_id, imem_addr,
        output ifid_valid, ifid_thread_id, ifid_pc, ifid_instr,
        output thread_active, all_halted, fetch_count0, fetch_count1,
        input  fetch_pc, imem_rdata, branch_taken, branch_thread_id
    );

    // PC table / memory / decode side
    modport slave (
        input  fetch_thread_id, imem_addr,
        input  ifid_valid, ifid_thread_id, ifid_pc, ifid_instr,
        input  thread_active, all_halted, fetch_count0, fetch_count1,
        output fetch_pc, imem_rdata, branch_taken, branch_thread_id
    );
endinterface

// File: rtl/thread_fetch_unit.sv
// Two-thread interleaved instruction fetch: picks a thread, reads imem at its PC, fills IF/ID, retires on HALT.
// Latency: 1 cycle from fetch (sel -> fetch_pc -> imem) to IF/ID.
// Backpressure: none; IF/ID reloads every edge, squashed or halted fetches load with valid low.
module thread_fetch_unit #(
    parameter int         INSTR_W     = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    thread_fetch_unit_if.master   bus
);

    logic               sel;
    logic               sel_next;
    logic [1:0]         active_q;
    logic [1:0]         active_next;
    logic               fetch_en;
    logic               squash;
    logic               entry_vld;
    logic               halt_hit;

    logic               ifid_valid_q;
    logic               ifid_thread_id_q;
    logic [7:0]         ifid_pc_q;
    logic [INSTR_W-1:0] ifid_instr_q;
    logic [15:0]        fetch_count0_q;
    logic [15:0]        fetch_count1_q;

    // Fetch qualification, HALT retirement and next-thread choice from the post-HALT active mask
    always_comb begin
        fetch_en    = active_q[sel];
        // The PC table redirects on this edge, so this cycle's fetch for the branching thread is wrong-path
        squash      = bus.branch_taken && (bus.branch_thread_id == sel);
        entry_vld   = fetch_en && !squash;
        halt_hit    = entry_vld && (bus.imem_rdata[15:12] == HALT_OPCODE);
        active_next = active_q;
        if (halt_hit) begin
            active_next[sel] = 1'b0;
        end
        case (active_next)
            2'b11:   sel_next = ~sel;
            2'b01:   sel_next = 1'b0;
            2'b10:   sel_next = 1'b1;
            default: sel_next = sel;
        endcase
    end

    // Scheduler and thread-liveness state; halted threads stay halted until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= 1'b0;
            active_q <= 2'b11;
        end else begin
            sel      <= sel_next;
            active_q <= active_next;
        end
    end

    // IF/ID register loads every edge; data fields follow the fetch even when the entry is dead
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_valid_q     <= 1'b0;
            ifid_thread_id_q <= 1'b0;
            ifid_pc_q        <= 8'd0;
            ifid_instr_q     <= '0;
        end else begin
            ifid_valid_q     <= entry_vld;
            ifid_thread_id_q <= sel;
            ifid_pc_q        <= bus.fetch_pc;
            ifid_instr_q     <= bus.imem_rdata;
        end
    end

    // Per-thread count of valid entries delivered to decode, wrapping at 16 bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count0_q <= 16'd0;
            fetch_count1_q <= 16'd0;
        end else if (entry_vld) begin
            if (sel) begin
                fetch_count1_q <= fetch_count1_q + 16'd1;
            end else begin
                fetch_count0_q <= fetch_count0_q + 16'd1;
            end
        end
    end

    // Odd PCs address the containing halfword; the full PC is kept in IF/ID
    assign bus.fetch_thread_id = sel;
    assign bus.imem_addr       = bus.fetch_pc[7:1];
    assign bus.ifid_valid      = ifid_valid_q;
    assign bus.ifid_thread_id  = ifid_thread_id_q;
    assign bus.ifid_pc         = ifid_pc_q;
    assign bus.ifid_instr      = ifid_instr_q;
    assign bus.thread_active   = active_q;
    assign bus.all_halted      = (active_q == 2'b00);
    assign bus.fetch_count0    = fetch_count0_q;
    assign bus.fetch_count1    = fetch_count1_q;

endmodule

// File: tb/tb_thread_fetch_unit.sv
// Directed bench for thread_fetch_unit with a behavioural PC table and instruction memory.
// Latency: checks IF/ID one edge after each fetch, sampled on the falling edge.
// Backpressure: none exercised; the design has no stall path.
module tb_thread_fetch_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc0;
    logic [7:0] pc1;
    logic [7:0] br_target;
    logic [15:0] imem [0:127];
    int n_checks = 0;
    int n_fail   = 0;

    thread_fetch_unit_if #(.INSTR_W(16)) bus ();

    thread_fetch_unit #(.INSTR_W(16), .HALT_OPCODE(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // PC table: post-increment the fetched thread, a taken branch overrides with its target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc0 <= 8'd0;
            pc1 <= 8'd100;
        end else begin
            if (bus.fetch_thread_id) pc1 <= pc1 + 8'd2;
            else                     pc0 <= pc0 + 8'd2;
            if (bus.branch_taken) begin
                if (bus.branch_thread_id) pc1 <= br_target;
                else                      pc0 <= br_target;
            end
        end
    end

    assign bus.fetch_pc   = bus.fetch_thread_id ? pc1 : pc0;
    assign bus.imem_rdata = imem[bus.imem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},  32'(bus.ifid_valid),      32'd0);
        check({tag, "_tid"},    32'(bus.ifid_thread_id),  32'd0);
        check({tag, "_pc"},     32'(bus.ifid_pc),         32'd0);
        check({tag, "_instr"},  32'(bus.ifid_instr),      32'd0);
        check({tag, "_active"}, 32'(bus.thread_active),   32'd3);
        check({tag, "_allh"},   32'(bus.all_halted),      32'd0);
        check({tag, "_cnt0"},   32'(bus.fetch_count0),    32'd0);
        check({tag, "_cnt1"},   32'(bus.fetch_count1),    32'd0);
        check({tag, "_sel"},    32'(bus.fetch_thread_id), 32'd0);
    endtask

    // Expected entries for the single-HALT run: thread 1 halts at PC 102
    logic       exp_tid [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [7:0] exp_pc  [0:6] = '{8'd0, 8'd100, 8'd2, 8'd102, 8'd4, 8'd6, 8'd8};

    initial begin
        rst                  = 1'b1;
        bus.branch_taken     = 1'b0;
        bus.branch_thread_id = 1'b0;
        br_target            = 8'd0;
        clear_mem();
        #2;
        check_reset("por");
        @(negedge clk);
        rst = 1'b0;

        // Plain interleave, no HALT or branch
        for (int i = 0; i < 6; i++) begin
            step();
            check("p1_valid", 32'(bus.ifid_valid), 32'd1);
            check("p1_tid",   32'(bus.ifid_thread_id), 32'(i % 2));
            check("p1_pc",    32'(bus.ifid_pc), 32'((i % 2) ? 100 + 2 * (i / 2) : 2 * (i / 2)));
        end
        check("p1_cnt0", 32'(bus.fetch_count0), 32'd3);
        check("p1_cnt1", 32'(bus.fetch_count1), 32'd3);

        // HALT at byte 102 retires thread 1; thread 0 then fetches every cycle
        clear_mem();
        imem[51] = 16'hF000;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step();
            check("p2_valid", 32'(bus.ifid_valid), 32'd1);
            check("p2_tid",   32'(bus.ifid_thread_id), 32'(exp_tid[i]));
            check("p2_pc",    32'(bus.ifid_pc), 32'(exp_pc[i]));
            if (i == 3) begin
                check("p2_halt_instr",  32'(bus.ifid_instr), 32'hF000);
                check("p2_halt_active", 32'(bus.thread_active), 32'd1);
            end
        end
        check("p2_cnt0",   32'(bus.fetch_count0), 32'd5);
        check("p2_cnt1",   32'(bus.fetch_count1), 32'd2);
        check("p2_active", 32'(bus.thread_active), 32'd1);
        check("p2_allh",   32'(bus.all_halted), 32'd0);

        // Branch squash on the selected thread, which also masks a HALT; then branch on the other thread
        clear_mem();
        imem[0] = 16'hF000;
        do_reset();
        bus.branch_taken     = 1'b1;
        bus.branch_thread_id = 1'b0;
        br_target            = 8'd40;
        step();
        check("p3_sq_valid",  32'(bus.ifid_valid), 32'd0);
        check("p3_sq_pc",     32'(bus.ifid_pc), 32'd0);
        check("p3_sq_active", 32'(bus.thread_active), 32'd3);
        check("p3_sq_cnt0",   32'(bus.fetch_count0), 32'd0);
        step();
        check("p3_ns_valid", 32'(bus.ifid_valid), 32'd1);
        check("p3_ns_tid",   32'(bus.ifid_thread_id), 32'd1);
        check("p3_ns_pc",    32'(bus.ifid_pc), 32'd100);
        bus.branch_taken = 1'b0;
        step();
        check("p3_tgt_valid", 32'(bus.ifid_valid), 32'd1);
        check("p3_tgt_tid",   32'(bus.ifid_thread_id), 32'd0);
        check("p3_tgt_pc",    32'(bus.ifid_pc), 32'd40);
        check("p3_cnt0",      32'(bus.fetch_count0), 32'd1);
        check("p3_cnt1",      32'(bus.fetch_count1), 32'd1);

        // Both threads halt; the last HALT freezes sel and everything after is dead
        clear_mem();
        imem[0]  = 16'hF000;
        imem[50] = 16'hF000;
        do_reset();
        step();
        check("p4_h0_valid",  32'(bus.ifid_valid), 32'd1);
        check("p4_h0_active", 32'(bus.thread_active), 32'd2);
        step();
        check("p4_h1_valid", 32'(bus.ifid_valid), 32'd1);
        check("p4_h1_pc",    32'(bus.ifid_pc), 32'd100);
        check("p4_allh",     32'(bus.all_halted), 32'd1);
        check("p4_active",   32'(bus.thread_active), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("p4_dead_valid", 32'(bus.ifid_valid), 32'd0);
            check("p4_dead_tid",   32'(bus.ifid_thread_id), 32'd1);
            check("p4_sel_hold",   32'(bus.fetch_thread_id), 32'd1);
        end
        check("p4_cnt0", 32'(bus.fetch_count0), 32'd1);
        check("p4_cnt1", 32'(bus.fetch_count1), 32'd1);

        // Counter wrap from 0xFFFF
        clear_mem();
        do_reset();
        force dut.fetch_count0_q = 16'hFFFF;
        #1;
        check("p5_preload", 32'(bus.fetch_count0), 32'hFFFF);
        release dut.fetch_count0_q;
        step();
        check("p5_valid", 32'(bus.ifid_valid), 32'd1);
        check("p5_wrap",  32'(bus.fetch_count0), 32'd0);

        // Asynchronous reset mid-run with a live IF/ID entry
        step();
        check("p6_pre_valid", 32'(bus.ifid_valid), 32'd1);
        check("p6_pre_pc",    32'(bus.ifid_pc), 32'd100);
        rst = 1'b1;
        #1;
        check_reset("p6_rst");
        @(negedge clk);
        rst = 1'b0;
        step();
        check("p6_first_valid", 32'(bus.ifid_valid), 32'd1);
        check("p6_first_tid",   32'(bus.ifid_thread_id), 32'd0);
        check("p6_first_pc",    32'(bus.ifid_pc), 32'd0);
        check("p6_first_cnt0",  32'(bus.fetch_count0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
